// File: rtl/code_entry.sv
// +----------------------------------------------------------------------------+
// | code_entry : keypad code capture, verify handshake and failure lockout       |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module code_entry #(
  parameter int                    DIGITS         = 4,
  parameter logic [2*DIGITS-1:0]   PASSWORD       = 8'b11_10_01_00,
  parameter int                    MAX_FAILS      = 3,
  parameter int                    LOCKOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  input  logic       enter_key,
  input  logic       clear_key,
  output logic       enter,
  output logic       clear,
  output logic       match,
  output logic       invalid,
  output logic [2:0] digit_count,
  output logic [1:0] fail_count,
  output logic       lockout,
  output logic [1:0] state
);

  localparam logic [2:0] C_DIGITS    = 3'(DIGITS);
  localparam logic [1:0] C_MAX_FAILS = 2'(MAX_FAILS);
  localparam logic [7:0] C_LOCK      = 8'(LOCKOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WAIT    = 2'd2,
    S_LOCKOUT = 2'd3
  } state_t;

  state_t              r_state, w_nxt_state;
  logic [3:0]          r_btn_q;
  logic                r_ent_q, r_clr_q, r_arm;
  logic [2*DIGITS-1:0] r_seq, w_nxt_seq;
  logic [2:0]          r_dcnt, w_nxt_dcnt;
  logic [1:0]          r_fcnt, w_nxt_fcnt;
  logic [7:0]          r_lcnt, w_nxt_lcnt;
  logic                r_wcnt, w_nxt_wcnt;
  logic                r_enter, r_clear, r_invalid, r_match, r_lockout;
  logic                w_enter, w_clear, w_invalid, w_match;
  logic                w_btn_ev, w_ent_ev, w_clr_ev;
  logic [1:0]          w_idx;
  logic [1:0]          w_fail_inc;

  // r_arm blocks events for the first cycle after reset so held keys need a re-press
  assign w_btn_ev = r_arm && (r_btn_q == 4'd0) && (btn != 4'd0);
  assign w_ent_ev = r_arm && !r_ent_q && enter_key;
  assign w_clr_ev = r_arm && !r_clr_q && clear_key;
  assign w_fail_inc = r_fcnt + 2'd1;

  always_comb begin
    w_idx = 2'd0;
    case (btn)
      4'b0010: w_idx = 2'd1;
      4'b0100: w_idx = 2'd2;
      4'b1000: w_idx = 2'd3;
      default: w_idx = 2'd0;
    endcase
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_seq   = r_seq;
    w_nxt_dcnt  = r_dcnt;
    w_nxt_fcnt  = r_fcnt;
    w_nxt_lcnt  = r_lcnt;
    w_nxt_wcnt  = r_wcnt;
    w_enter     = 1'b0;
    w_clear     = 1'b0;
    w_invalid   = 1'b0;
    w_match     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_clr_ev) begin
          w_clear    = 1'b1;
          w_nxt_dcnt = 3'd0;
          w_nxt_seq  = '0;
        end else if (w_ent_ev) begin
          w_enter     = 1'b1;
          w_nxt_dcnt  = 3'd0;
          w_nxt_state = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (w_clr_ev) begin
          w_clear     = 1'b1;
          w_nxt_dcnt  = 3'd0;
          w_nxt_seq   = '0;
          w_nxt_state = S_IDLE;
        end else if (w_ent_ev) begin
          if (r_dcnt == C_DIGITS) begin
            w_enter     = 1'b1;
            w_nxt_wcnt  = 1'b0;
            w_match     = (r_seq == PASSWORD);
            w_nxt_state = S_WAIT;
          end else begin
            w_invalid = 1'b1;
          end
        end else if (w_btn_ev) begin
          if (r_dcnt == C_DIGITS) begin
            w_invalid = 1'b1;
          end else if (!$onehot(btn)) begin
            w_invalid  = 1'b1;
            w_nxt_dcnt = 3'd0;
          end else begin
            for (int k = 0; k < DIGITS; k++) begin
              if (r_dcnt == 3'(k)) w_nxt_seq[2*k +: 2] = w_idx;
            end
            w_nxt_dcnt = r_dcnt + 3'd1;
          end
        end
      end
      S_WAIT: begin
        if (w_clr_ev) begin
          w_clear     = 1'b1;
          w_nxt_dcnt  = 3'd0;
          w_nxt_seq   = '0;
          w_nxt_state = S_IDLE;
        end else if (!r_wcnt) begin
          w_nxt_wcnt = 1'b1;
          w_match    = (r_seq == PASSWORD);
        end else begin
          w_nxt_dcnt = 3'd0;
          if (r_seq == PASSWORD) begin
            w_nxt_fcnt  = 2'd0;
            w_nxt_state = S_IDLE;
          end else begin
            w_nxt_fcnt = w_fail_inc;
            if (w_fail_inc == C_MAX_FAILS) begin
              w_nxt_lcnt  = C_LOCK;
              w_nxt_state = S_LOCKOUT;
            end else begin
              w_nxt_state = S_IDLE;
            end
          end
        end
      end
      default: begin
        // Counter was loaded with the full duration on entry, so leave on 1
        if (r_lcnt <= 8'd1) begin
          w_clear     = 1'b1;
          w_nxt_fcnt  = 2'd0;
          w_nxt_dcnt  = 3'd0;
          w_nxt_lcnt  = 8'd0;
          w_nxt_state = S_IDLE;
        end else begin
          w_nxt_lcnt = r_lcnt - 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_btn_q   <= 4'd0;
      r_ent_q   <= 1'b0;
      r_clr_q   <= 1'b0;
      r_arm     <= 1'b0;
      r_seq     <= '0;
      r_dcnt    <= 3'd0;
      r_fcnt    <= 2'd0;
      r_lcnt    <= 8'd0;
      r_wcnt    <= 1'b0;
      r_enter   <= 1'b0;
      r_clear   <= 1'b0;
      r_invalid <= 1'b0;
      r_match   <= 1'b0;
      r_lockout <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_btn_q   <= btn;
      r_ent_q   <= enter_key;
      r_clr_q   <= clear_key;
      r_arm     <= 1'b1;
      r_seq     <= w_nxt_seq;
      r_dcnt    <= w_nxt_dcnt;
      r_fcnt    <= w_nxt_fcnt;
      r_lcnt    <= w_nxt_lcnt;
      r_wcnt    <= w_nxt_wcnt;
      r_enter   <= w_enter;
      r_clear   <= w_clear;
      r_invalid <= w_invalid;
      r_match   <= w_match;
      r_lockout <= (w_nxt_state == S_LOCKOUT);
    end
  end

  assign enter       = r_enter;
  assign clear       = r_clear;
  assign invalid     = r_invalid;
  assign match       = r_match;
  assign digit_count = r_dcnt;
  assign fail_count  = r_fcnt;
  assign lockout     = r_lockout;
  assign state       = r_state;

endmodule

`default_nettype wire

// File: tb/tb_code_entry.sv
// +----------------------------------------------------------------------------+
// | tb_code_entry : directed self-checking bench for code_entry                  |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_code_entry;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn;
  logic       enter_key, clear_key;
  logic       enter, clear, match, invalid, lockout;
  logic [2:0] digit_count;
  logic [1:0] fail_count, state;

  int n_cmp = 0;
  int n_bad = 0;

  code_entry dut (
    .clk         (clk),
    .reset       (reset),
    .btn         (btn),
    .enter_key   (enter_key),
    .clear_key   (clear_key),
    .enter       (enter),
    .clear       (clear),
    .match       (match),
    .invalid     (invalid),
    .digit_count (digit_count),
    .fail_count  (fail_count),
    .lockout     (lockout),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [1:0] st, input logic en,
                            input logic cl, input logic inv, input logic mt,
                            input logic [2:0] dc, input logic [1:0] fc, input logic lk);
    chk({tag, ".state"},   32'(state),       32'(st));
    chk({tag, ".enter"},   32'(enter),       32'(en));
    chk({tag, ".clear"},   32'(clear),       32'(cl));
    chk({tag, ".invalid"}, 32'(invalid),     32'(inv));
    chk({tag, ".match"},   32'(match),       32'(mt));
    chk({tag, ".dcnt"},    32'(digit_count), 32'(dc));
    chk({tag, ".fcnt"},    32'(fail_count),  32'(fc));
    chk({tag, ".lockout"}, 32'(lockout),     32'(lk));
  endtask

  // Drive inputs, let one rising edge pass, sample 1 ns later
  task automatic step(input logic [3:0] b, input logic e, input logic c);
    btn = b; enter_key = e; clear_key = c;
    @(posedge clk);
    #1;
  endtask

  // Wrong code 3,3,3,3 up to the point of entering WAIT
  task automatic wrong_attempt(input logic [1:0] fc);
    step(4'd0, 1'b1, 1'b0);
    expect_out("wr_start", 2'd1, 1, 0, 0, 0, 3'd0, fc, 0);
    step(4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(4'b1000, 1'b0, 1'b0);
      step(4'd0, 1'b0, 1'b0);
    end
    step(4'd0, 1'b1, 1'b0);
    expect_out("wr_wait1", 2'd2, 1, 0, 0, 0, 3'd4, fc, 0);
    step(4'd0, 1'b0, 1'b0);
    expect_out("wr_wait2", 2'd2, 0, 0, 0, 0, 3'd4, fc, 0);
    step(4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b0; btn = 4'd0; enter_key = 1'b0; clear_key = 1'b0;
    step(4'd0, 1'b0, 1'b0);
    step(4'd0, 1'b0, 1'b0);
    expect_out("reset", 2'd0, 0, 0, 0, 0, 3'd0, 2'd0, 0);
    reset = 1'b1;
    step(4'd0, 1'b0, 1'b0);
    step(4'd0, 1'b0, 1'b0);

    // Correct code 0,1,2,3
    step(4'd0, 1'b1, 1'b0);
    expect_out("ok_enter", 2'd1, 1, 0, 0, 0, 3'd0, 2'd0, 0);
    step(4'd0, 1'b0, 1'b0);
    chk("ok_enter_pulse_end", 32'(enter), 32'd0);
    for (int d = 0; d < 4; d++) begin
      step(4'(1 << d), 1'b0, 1'b0);
      chk("ok_digit", 32'(digit_count), 32'(d + 1));
      step(4'd0, 1'b0, 1'b0);
    end
    step(4'd0, 1'b1, 1'b0);
    expect_out("ok_wait1", 2'd2, 1, 0, 0, 1, 3'd4, 2'd0, 0);
    step(4'd0, 1'b0, 1'b0);
    expect_out("ok_wait2", 2'd2, 0, 0, 0, 1, 3'd4, 2'd0, 0);
    step(4'd0, 1'b0, 1'b0);
    expect_out("ok_done", 2'd0, 0, 0, 0, 0, 3'd0, 2'd0, 0);

    // Three wrong attempts lead to lockout
    wrong_attempt(2'd0);
    expect_out("wr1_done", 2'd0, 0, 0, 0, 0, 3'd0, 2'd1, 0);
    wrong_attempt(2'd1);
    expect_out("wr2_done", 2'd0, 0, 0, 0, 0, 3'd0, 2'd2, 0);
    wrong_attempt(2'd2);
    expect_out("lock_enter", 2'd3, 0, 0, 0, 0, 3'd0, 2'd3, 1);
    for (int i = 1; i < 16; i++) begin
      if (i % 2 == 1) step(4'b0001, 1'b1, 1'b1);
      else            step(4'd0, 1'b0, 1'b0);
      chk("lock_hold", 32'(lockout), 32'd1);
      chk("lock_state", 32'(state), 32'd3);
      chk("lock_no_pulse", 32'({enter, clear, invalid}), 32'd0);
    end
    step(4'd0, 1'b0, 1'b0);
    expect_out("lock_expire", 2'd0, 0, 1, 0, 0, 3'd0, 2'd0, 0);
    step(4'd0, 1'b0, 1'b0);
    chk("lock_clear_once", 32'(clear), 32'd0);

    // Multi-hot button in COLLECT with two digits captured
    step(4'd0, 1'b1, 1'b0);
    step(4'd0, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0); step(4'd0, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0); step(4'd0, 1'b0, 1'b0);
    chk("mh_pre", 32'(digit_count), 32'd2);
    step(4'b0011, 1'b0, 1'b0);
    expect_out("multihot", 2'd1, 0, 0, 1, 0, 3'd0, 2'd0, 0);
    step(4'd0, 1'b0, 1'b0);
    chk("mh_pulse_end", 32'(invalid), 32'd0);

    // Early enter, then clear and enter in the same cycle
    step(4'b0001, 1'b0, 1'b0); step(4'd0, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0); step(4'd0, 1'b0, 1'b0);
    step(4'd0, 1'b1, 1'b0);
    expect_out("early_enter", 2'd1, 0, 0, 1, 0, 3'd2, 2'd0, 0);
    step(4'd0, 1'b0, 1'b0);
    step(4'd0, 1'b1, 1'b1);
    expect_out("clr_prio", 2'd0, 0, 1, 0, 0, 3'd0, 2'd0, 0);
    step(4'd0, 1'b0, 1'b0);
    chk("clr_pulse_end", 32'(clear), 32'd0);

    // Held button counts once
    step(4'd0, 1'b1, 1'b0);
    step(4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(4'b0010, 1'b0, 1'b0);
      chk("held_btn", 32'(digit_count), 32'd1);
    end
    step(4'd0, 1'b0, 1'b0);

    // Reset mid-COLLECT with three digits
    step(4'b0001, 1'b0, 1'b0); step(4'd0, 1'b0, 1'b0);
    step(4'b1000, 1'b0, 1'b0); step(4'd0, 1'b0, 1'b0);
    chk("rst_pre", 32'(digit_count), 32'd3);
    reset = 1'b0;
    step(4'd0, 1'b1, 1'b0);
    expect_out("rst_mid", 2'd0, 0, 0, 0, 0, 3'd0, 2'd0, 0);

    // Enter held through reset release produces no event until re-pressed
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(4'd0, 1'b1, 1'b0);
      chk("held_rst_state", 32'(state), 32'd0);
      chk("held_rst_enter", 32'(enter), 32'd0);
    end
    step(4'd0, 1'b0, 1'b0);
    step(4'd0, 1'b1, 1'b0);
    expect_out("repress", 2'd1, 1, 0, 0, 0, 3'd0, 2'd0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
